sw_led_debounce: RTL

SW_LED_DEBOUNCE -- requirements
Module: sw_led_debounce

---
 rtl/sw_led_pkg.sv | 10 +
 rtl/debounce_bit.sv | 67 ++++++
 rtl/sw_led_debounce.sv | 36 +++
 3 files changed

// File: rtl/sw_led_pkg.sv
// Shared defaults and counter sizing for the switch/LED debouncer.
// Define SW_LED_DEBOUNCE_EN to build the per-channel debounce counters.
package sw_led_pkg;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_DEBOUNCE = 4;

    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/debounce_bit.sv
// One switch channel: two-flop synchronizer, stability counter, LED bit.
// SW_LED_DEBOUNCE_EN selects the counted debounce; otherwise LED follows s2.
module debounce_bit
    import sw_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic sw,
    output logic led,
    output logic upd
);
    logic s1, s2;

    if (DEBOUNCE_CYCLES < 1) begin : g_dc_out_of_range
        // No legal configuration elaborates this block.
    end

`ifdef SW_LED_DEBOUNCE_EN
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            led <= 1'b0;
            upd <= 1'b0;
            cnt <= '0;
        end else begin
            s1  <= sw;
            s2  <= s1;
            upd <= 1'b0;
            // Any return to the LED level restarts the stability window.
            if (hold || s2 == led) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                led <= s2;
                upd <= 1'b1;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            led <= 1'b0;
            upd <= 1'b0;
        end else begin
            s1  <= sw;
            s2  <= s1;
            upd <= 1'b0;
            if (!hold && s2 != led) begin
                led <= s2;
                upd <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: rtl/sw_led_debounce.sv
// Top: WIDTH independent debounce channels plus the CHANGED pulse register.
// Debounce counters are built only when SW_LED_DEBOUNCE_EN is defined.
module sw_led_debounce
    import sw_led_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
    input  logic             CLK,
    input  logic             CPU_RESETN,
    input  logic [WIDTH-1:0] SW,
    input  logic             HOLD,
    output logic [WIDTH-1:0] LED,
    output logic             CHANGED
);
    logic [WIDTH-1:0] upd;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk  (CLK),
            .rst_n(CPU_RESETN),
            .hold (HOLD),
            .sw   (SW[g]),
            .led  (LED[g]),
            .upd  (upd[g])
        );
    end

    // upd marks the edge LED moved; registering it lands CHANGED one cycle later.
    always_ff @(posedge CLK) begin
        if (!CPU_RESETN) CHANGED <= 1'b0;
        else             CHANGED <= |upd;
    end
endmodule
